// File: rtl/fifo_word_packer_if.sv
// Handshake bundle between the show-ahead byte FIFO, the packer and the word consumer.
// The slave modport is the packer; the master modport is whatever surrounds it.
interface fifo_word_packer_if #(
    parameter int BYTE_SIZE      = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int CNT_W          = 3
);
    logic                                empty;
    logic [BYTE_SIZE-1:0]                rdata;
    logic                                rreq;
    logic                                out_valid;
    logic                                out_ready;
    logic [BYTE_SIZE*BYTES_PER_WORD-1:0] out_data;
    logic [CNT_W-1:0]                    out_count;

    modport master (
        output empty, rdata, out_ready,
        input  rreq, out_valid, out_data, out_count
    );

    modport slave (
        input  empty, rdata, out_ready,
        output rreq, out_valid, out_data, out_count
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops bytes from a show-ahead FIFO and packs BYTES_PER_WORD of them (first byte in lane 0)
// into a word on a valid/ready port; flush pushes out a partial word with its lane count.
module fifo_word_packer #(
    parameter int BYTE_SIZE      = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int CNT_W          = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    output logic              busy,
    fifo_word_packer_if.slave bus
);
    localparam int              N    = BYTES_PER_WORD;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(N);

    typedef logic [N-1:0][BYTE_SIZE-1:0] word_t;

    word_t            acc_q, acc_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    word_t            out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_valid_q, out_valid_d;

    logic  slot_free;
    logic  last_lane;
    logic  pop;
    word_t full_word;
    word_t part_word;

    assign slot_free = !out_valid_q || bus.out_ready;
    assign last_lane = (acc_cnt_q == LAST);
    // Only the last lane needs a free output slot; earlier lanes keep filling under back-pressure.
    assign pop = reset_n && !bus.empty && !flush && (!last_lane || slot_free);

    always_comb begin
        full_word        = acc_q;
        full_word[N-1]   = bus.rdata;
        part_word        = '0;
        for (int k = 0; k < N; k++) begin
            if (CNT_W'(k) < acc_cnt_q) part_word[k] = acc_q[k];
        end
    end

    always_comb begin
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

        if (pop) begin
            if (last_lane) begin
                out_data_d  = full_word;
                out_count_d = FULL;
                out_valid_d = 1'b1;
                acc_d       = '0;
                acc_cnt_d   = '0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (CNT_W'(k) == acc_cnt_q) acc_d[k] = bus.rdata;
                end
                acc_cnt_d = acc_cnt_q + 1'b1;
            end
        end else if (flush && acc_cnt_q != '0 && slot_free) begin
            out_data_d  = part_word;
            out_count_d = acc_cnt_q;
            out_valid_d = 1'b1;
            acc_d       = '0;
            acc_cnt_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.rreq      = pop;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign busy          = (acc_cnt_q != '0) || out_valid_q;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: a queue models the show-ahead FIFO, a table of
// full-word vectors is replayed, and hand-written sequences cover stall, flush and reset.
module tb_fifo_word_packer;
    localparam int BS = 8;
    localparam int N  = 4;
    localparam int CW = 3;

    logic clock = 1'b0;
    logic reset_n;
    logic flush;
    logic busy;

    fifo_word_packer_if #(.BYTE_SIZE(BS), .BYTES_PER_WORD(N), .CNT_W(CW)) bus ();

    fifo_word_packer #(.BYTE_SIZE(BS), .BYTES_PER_WORD(N), .CNT_W(CW)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .flush  (flush),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] word;
    } vec_t;

    vec_t       tbl [4];
    logic [7:0] q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply();
        bus.empty = (q.size() == 0);
        bus.rdata = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    // Runs from just after a negedge to just after the next negedge; pops the model FIFO
    // whenever rreq was high going into the posedge.
    task automatic cyc();
        logic rr;
        apply();
        #1;
        rr = bus.rreq;
        @(posedge clock);
        if (rr && q.size() != 0) void'(q.pop_front());
        @(negedge clock);
        apply();
        #1;
    endtask

    task automatic wait_word(output int pops, output bit ok);
        pops = 0;
        ok   = 1'b0;
        apply();
        #1;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            if (bus.rreq) pops++;
            cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         pops;
        bit         ok;
        int         got;
        logic [31:0] w [3];
        int         at [3];

        tbl[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
        tbl[1] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};
        tbl[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF00FF};
        tbl[3] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};

        // Reset with a non-empty FIFO
        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        q.push_back(8'h5A);
        apply();
        @(negedge clock);
        #1;
        chk("rst_rreq",  32'(bus.rreq), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data",  bus.out_data, 0);
        chk("rst_count", 32'(bus.out_count), 0);
        chk("rst_busy",  32'(busy), 0);
        reset_n = 1'b1;
        apply();
        #1;
        chk("rel_rreq", 32'(bus.rreq), 1);
        cyc();
        chk("rel_busy", 32'(busy), 1);
        flush = 1'b1;
        cyc();
        chk("f1_valid", 32'(bus.out_valid), 1);
        chk("f1_count", 32'(bus.out_count), 1);
        chk("f1_data",  bus.out_data, 32'h0000005A);
        flush = 1'b0;
        cyc();
        chk("f1_drop", 32'(bus.out_valid), 0);
        chk("f1_idle", 32'(busy), 0);

        // Full words, streaming with out_ready=1
        for (int v = 0; v < 4; v++) begin
            q.push_back(tbl[v].b0);
            q.push_back(tbl[v].b1);
            q.push_back(tbl[v].b2);
            q.push_back(tbl[v].b3);
            wait_word(pops, ok);
            chk($sformatf("vec%0d_tmo", v),   32'(ok), 1);
            chk($sformatf("vec%0d_pops", v),  32'(pops), 4);
            chk($sformatf("vec%0d_data", v),  bus.out_data, tbl[v].word);
            chk($sformatf("vec%0d_count", v), 32'(bus.out_count), 4);
            cyc();
            chk($sformatf("vec%0d_once", v),  32'(bus.out_valid), 0);
        end

        // Back-pressure: first word held, accumulator fills to the last lane then stalls
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 12; i++) q.push_back(8'(i));
        for (int i = 0; i < 10; i++) cyc();
        chk("bp_valid", 32'(bus.out_valid), 1);
        chk("bp_data",  bus.out_data, 32'h04030201);
        chk("bp_rreq",  32'(bus.rreq), 0);
        chk("bp_empty", 32'(bus.empty), 0);
        chk("bp_left",  32'(q.size()), 5);
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (bus.out_valid) begin
                w[got]  = bus.out_data;
                at[got] = c;
                got++;
            end
            cyc();
        end
        chk("bp_words", 32'(got), 3);
        chk("bp_w0", w[0], 32'h04030201);
        chk("bp_w1", w[1], 32'h08070605);
        chk("bp_w2", w[2], 32'h0C0B0A09);
        chk("bp_b2b", 32'(at[1] - at[0]), 1);
        chk("bp_drained", 32'(q.size()), 0);
        chk("bp_idle", 32'(busy), 0);

        // Flush of a 2-byte partial, then a second flush with nothing accumulated
        q.push_back(8'hAA);
        q.push_back(8'hBB);
        cyc();
        cyc();
        chk("fp_empty", 32'(bus.empty), 1);
        flush = 1'b1;
        cyc();
        chk("fp_valid", 32'(bus.out_valid), 1);
        chk("fp_data",  bus.out_data, 32'h0000BBAA);
        chk("fp_count", 32'(bus.out_count), 2);
        cyc();
        chk("fp_second", 32'(bus.out_valid), 0);
        cyc();
        chk("fp_third", 32'(bus.out_valid), 0);
        flush = 1'b0;

        // Flush wins over a non-empty FIFO
        q.push_back(8'h77);
        q.push_back(8'h88);
        cyc();
        flush = 1'b1;
        apply();
        #1;
        chk("fd_rreq",  32'(bus.rreq), 0);
        chk("fd_empty", 32'(bus.empty), 0);
        cyc();
        chk("fd_valid", 32'(bus.out_valid), 1);
        chk("fd_count", 32'(bus.out_count), 1);
        chk("fd_data",  bus.out_data, 32'h00000077);
        chk("fd_held",  32'(q.size()), 1);
        flush = 1'b0;
        q.push_back(8'h99);
        q.push_back(8'hAB);
        q.push_back(8'hCD);
        cyc();
        wait_word(pops, ok);
        chk("fd_tmo",   32'(ok), 1);
        chk("fd_word",  bus.out_data, 32'hCDAB9988);
        chk("fd_wcnt",  32'(bus.out_count), 4);
        cyc();

        // Asynchronous reset between edges, mid-word
        q.push_back(8'h21);
        q.push_back(8'h22);
        q.push_back(8'h23);
        cyc();
        cyc();
        cyc();
        chk("ar_busy_pre", 32'(busy), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("ar_busy",  32'(busy), 0);
        chk("ar_valid", 32'(bus.out_valid), 0);
        chk("ar_rreq",  32'(bus.rreq), 0);
        #1 reset_n = 1'b1;
        q.push_back(8'h31);
        q.push_back(8'h32);
        q.push_back(8'h33);
        q.push_back(8'h34);
        @(negedge clock);
        wait_word(pops, ok);
        chk("ar_tmo",   32'(ok), 1);
        chk("ar_pops",  32'(pops), 4);
        chk("ar_data",  bus.out_data, 32'h34333231);
        chk("ar_count", 32'(bus.out_count), 4);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
Downstream consumer stage for the show-ahead byte FIFO. It pops bytes through the FIFO's rreq/rdata/empty interface and packs BYTES_PER_WORD consecutive bytes into one word, first byte in the least-significant lane. Each packed word is presented on a valid/ready output port. A flush input forces a partial word out, together with its valid-byte count.

Parameters:
BYTE_SIZE, 8, width of one FIFO entry / one lane.
BYTES_PER_WORD, 4, lanes per output word (>=2).
CNT_W, 3, width of the lane counter and out_count; must satisfy 2**CNT_W > BYTES_PER_WORD.

Ports:
clock  input  1  single clock; all state updates on posedge clock.
reset_n  input  1  asynchronous, active-low reset.
empty  input  1  FIFO empty flag.
rdata  input  BYTE_SIZE  FIFO head byte; valid whenever empty=0 (show-ahead).
rreq  output  1  pop request to FIFO; combinational.
flush  input  1  level; emit any partial word and hold off popping.
out_valid  output  1  out_data/out_count hold a word.
out_ready  input  1  downstream accepts the word when out_valid&&out_ready at posedge.
out_data  output  BYTE_SIZE*BYTES_PER_WORD  packed word; lane k = bits [k*BYTE_SIZE +: BYTE_SIZE].
out_count  output  CNT_W  number of valid lanes (1..BYTES_PER_WORD).
busy  output  1  acc_cnt!=0 || out_valid.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clock, reset_n).
- State: accumulator acc (BYTES_PER_WORD lanes), acc_cnt (0..BYTES_PER_WORD-1), output register {out_data, out_count, out_valid}.
- Reset (reset_n=0, asynchronous): acc, acc_cnt, out_data, out_count, out_valid all 0. rreq=0 and busy=0 while reset_n=0.
- slot_free = !out_valid || out_ready.
- rreq = reset_n && !empty && !flush && (acc_cnt != BYTES_PER_WORD-1 || slot_free). rreq is never asserted while empty=1.
- Byte accept (rreq=1): at posedge, rdata is written to lane acc_cnt.
  - acc_cnt != N-1: acc_cnt increments.
  - acc_cnt == N-1: the full word (acc lanes 0..N-2 plus rdata in lane N-1) loads into the output register; out_count=N, out_valid=1, acc and acc_cnt cleared to 0.
  - Latency from the posedge that pops the last byte to out_valid=1: that same edge (visible the next cycle).
- Throughput: one byte per cycle sustained. A full word drains every N cycles when out_ready=1. Popping continues into the accumulator while the output is held, stalling only on the last lane.
- Output hold: while out_valid && !out_ready, out_data and out_count are stable.
  - out_valid clears on the accepting edge unless a new word loads on the same edge; then out_valid stays 1 with the new data (back-to-back).
- Flush: while flush=1, rreq=0.
  - If acc_cnt>0 && slot_free, at posedge the output register loads acc with unused lanes zeroed; out_count=acc_cnt, out_valid=1, acc_cnt=0.
  - acc_cnt==0: no output; flush has no effect.
  - Holding flush high emits at most one partial word, because acc is then empty.
- Simultaneous flush and a non-empty FIFO: flush wins, no pop that cycle.
- Reset mid-operation: accumulated and held bytes are discarded. Bytes already popped from the FIFO are lost by design.
- Arithmetic: acc_cnt is modulo-free; it never exceeds N-1. out_count is zero-extended to CNT_W.

Test Plan:
- Reset: reset_n=0 with empty=0 -> rreq=0, out_valid=0, out_data=0, out_count=0, busy=0. Releasing reset with FIFO non-empty -> rreq=1 the next cycle.
- Full word, N=4: FIFO holds 0x11,0x22,0x33,0x44, out_ready=1 -> rreq high 4 cycles; after the 4th pop, out_valid=1, out_data=0x44332211, out_count=4 for exactly one cycle.
- Back-pressure: 12 bytes 0x01..0x0C, out_ready=0 -> first word 0x04030201 held. Popping continues to acc_cnt=3, then rreq=0 with FIFO non-empty. out_ready=1 -> words 0x08070605 and 0x0C0B0A09 follow with no gap and no byte loss.
- Flush partial: 0xAA,0xBB popped, empty=1, flush pulse -> out_data=0x0000BBAA, out_count=2. A second flush with acc empty -> no output.
- Flush vs data: flush=1 with FIFO non-empty and acc_cnt=1 -> rreq=0; a 1-byte word is emitted. After flush drops, popping resumes into lane 0.
- Async reset mid-word: assert reset_n=0 between posedges after 3 bytes popped -> acc_cnt=0 and out_valid=0 immediately. The next 4 bytes form a fresh word.
